// File: rtl/profibus_rx_sequencer_pkg.sv
// Shared definitions for the PROFIBUS receive sequencer.
//   - rx_state_e : receive FSM state encoding (3 bits, IDLE..STOP)
//   - DATA_BITS / PARITY_EVEN : PROFIBUS character format (8 data bits, even parity)
//   - IDX_W : width of the data-bit index
//   - parity_err() : parity check over a data byte plus the received parity bit
`ifndef PROFIBUS_RX_SEQUENCER_PKG_SV
`define PROFIBUS_RX_SEQUENCER_PKG_SV

package profibus_rx_sequencer_pkg;

  localparam int   DATA_BITS   = 8;
  localparam int   IDX_W       = $clog2(DATA_BITS);
  localparam logic PARITY_EVEN = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  // Returns 1 when the received parity bit does not match the data.
  // For even parity the XOR of data and parity bit must be 0.
  function automatic logic parity_err(input logic [DATA_BITS-1:0] data,
                                      input logic                 par_bit);
    return (^data) ^ par_bit ^ ~PARITY_EVEN;
  endfunction

endpackage

`endif

// File: rtl/profibus_rx_sequencer_if.sv
// Receive-side bus of the PROFIBUS RX sequencer.
//   rx_in         : raw RX line (idle high), driven by the PHY side
//   rx_data       : last received data byte
//   rx_valid      : one-cycle pulse when rx_data and the flags update
//   rx_parity_err : even-parity mismatch on last character
//   rx_frame_err  : stop bit sampled low on last character
//   rx_busy       : character reception in progress
// Modports: slave = the sequencer, master = the line driver / byte consumer.
interface profibus_rx_sequencer_if;
  import profibus_rx_sequencer_pkg::*;

  logic                 rx_in;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_parity_err;
  logic                 rx_frame_err;
  logic                 rx_busy;

  modport slave (
    input  rx_in,
    output rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_busy
  );

  modport master (
    output rx_in,
    input  rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_busy
  );
endinterface

// File: rtl/profibus_rx_sequencer_sync_signal.sv
// sync_signal: two-flop synchroniser with falling-edge detector.
//   clk, rst : clock, synchronous active-high reset
//   sig_in   : asynchronous input
//   level    : synchronised level (2 clk after sig_in changes)
//   fall     : high for one cycle in the cycle level first reads 0
// Flops reset to 1 so an idle-high line never produces a spurious edge.
module sync_signal (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic level,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = sig_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q;
  assign fall  = prev_q & ~sync_q;

endmodule

// File: rtl/profibus_rx_sequencer.sv
// profibus_rx_sequencer: receives PROFIBUS UART characters
// (start, 8 data bits LSB first, even parity, stop) and emits one byte per
// character together with parity and framing status.
//   clk, rst : clock, synchronous active-high reset
//   bus      : profibus_rx_sequencer_if.slave (rx_in in; rx_data, rx_valid,
//              rx_parity_err, rx_frame_err, rx_busy out)
// Bit timing starts from the synchronised falling edge of the start bit;
// every bit is sampled near its middle.
module profibus_rx_sequencer
  import profibus_rx_sequencer_pkg::*;
#(
  parameter  int CLKS_PER_BIT = 104,
  localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic                    clk,
  input  logic                    rst,
  profibus_rx_sequencer_if.slave  bus
);

  if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
    $error("profibus_rx_sequencer: CLKS_PER_BIT must be >= 4");
  end

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

  logic rx_level;
  logic rx_fall;

  sync_signal u_sync (
    .clk    (clk),
    .rst    (rst),
    .sig_in (bus.rx_in),
    .level  (rx_level),
    .fall   (rx_fall)
  );

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_parity_err_q, rx_parity_err_d;
  logic                 rx_frame_err_q, rx_frame_err_d;
  logic                 rx_busy_q, rx_busy_d;
  logic                 sample;

  assign sample = (cnt_q == '0);

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    idx_d           = idx_q;
    shreg_d         = shreg_q;
    par_d           = par_q;
    rx_data_d       = rx_data_q;
    rx_valid_d      = 1'b0;
    rx_parity_err_d = rx_parity_err_q;
    rx_frame_err_d  = rx_frame_err_q;

    // The counter free-runs in every active state; a sample fires on zero
    // and reloads a full bit period so later samples stay mid-bit.
    if (state_q != ST_IDLE) begin
      cnt_d = sample ? FULL_LOAD : cnt_q - CNT_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        // Only a fresh falling edge starts a character, so a line held low
        // after a break cannot restart reception until it goes high again.
        if (rx_fall) begin
          state_d = ST_START;
          cnt_d   = HALF_LOAD;
        end
      end
      ST_START: begin
        if (sample) begin
          if (!rx_level) begin
            state_d = ST_DATA;
            idx_d   = '0;
          end else begin
            state_d = ST_IDLE;  // start bit did not persist: glitch
          end
        end
      end
      ST_DATA: begin
        if (sample) begin
          shreg_d[idx_q] = rx_level;
          if (idx_q == LAST_IDX) begin
            state_d = ST_PARITY;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (sample) begin
          par_d   = parity_err(shreg_q, rx_level);
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (sample) begin
          rx_data_d       = shreg_q;
          rx_parity_err_d = par_q;
          rx_frame_err_d  = ~rx_level;
          rx_valid_d      = 1'b1;
          state_d         = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    rx_busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      idx_q           <= '0;
      shreg_q         <= '0;
      par_q           <= 1'b0;
      rx_data_q       <= '0;
      rx_valid_q      <= 1'b0;
      rx_parity_err_q <= 1'b0;
      rx_frame_err_q  <= 1'b0;
      rx_busy_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      idx_q           <= idx_d;
      shreg_q         <= shreg_d;
      par_q           <= par_d;
      rx_data_q       <= rx_data_d;
      rx_valid_q      <= rx_valid_d;
      rx_parity_err_q <= rx_parity_err_d;
      rx_frame_err_q  <= rx_frame_err_d;
      rx_busy_q       <= rx_busy_d;
    end
  end

  assign bus.rx_data       = rx_data_q;
  assign bus.rx_valid      = rx_valid_q;
  assign bus.rx_parity_err = rx_parity_err_q;
  assign bus.rx_frame_err  = rx_frame_err_q;
  assign bus.rx_busy       = rx_busy_q;

endmodule
